// File: rtl/car_sprite_blitter_pkg.sv
// Shared constants and state type for the car sprite blitter and its scan counter.
package car_game_pkg;

   localparam int SPR_W    = 8;
   localparam int SPR_H    = 8;
   localparam int SCR_W    = 160;
   localparam int SCR_H    = 120;
   localparam int COLOUR_W = 3;
   localparam int COL_W    = $clog2(SPR_W);
   localparam int ROW_W    = $clog2(SPR_H);

   typedef enum logic [1:0] {
      IDLE,
      ERASE,
      DRAW,
      FLUSH
   } blit_state_t;

endpackage

// File: rtl/car_sprite_blitter_scan_ctr.sv
// Nested column/row counter walking one sprite footprint in raster order.
module sprite_scan_ctr
   import car_game_pkg::*;
(
   input  logic             clk,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [COL_W-1:0] col_o,
   output logic [ROW_W-1:0] row_o,
   output logic             last_o
);

   localparam logic [COL_W-1:0] COL_MAX = COL_W'(SPR_W - 1);
   localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(SPR_H - 1);

   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;

   // Clear wins over enable so the FSM can restart the scan in the same cycle it ends one.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (clr_i) begin
         col_d = '0;
         row_d = '0;
      end else if (en_i) begin
         col_d = col_q + 1'b1;
         if (col_q == COL_MAX) begin
            row_d = row_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   assign col_o  = col_q;
   assign row_o  = row_q;
   assign last_o = (col_q == COL_MAX) && (row_q == ROW_MAX);

endmodule

// File: rtl/car_sprite_blitter.sv
// Erases the car's old footprint from the background ROM, then draws the sprite at the new position.
// Optional build macro CAR_SPRITE_TRANSPARENT_EN: black sprite pixels are not plotted.
module car_sprite_blitter
   import car_game_pkg::*;
(
   input  logic                clk,
   input  logic                rst_i,
   input  logic                req_i,
   input  logic [7:0]          new_x_i,
   input  logic [6:0]          new_y_i,
   output logic                busy_o,
   output logic                done_o,
   output logic [5:0]          spr_addr_o,
   input  logic [COLOUR_W-1:0] spr_colour_i,
   output logic [14:0]         bg_addr_o,
   input  logic [COLOUR_W-1:0] bg_colour_i,
   output logic [7:0]          x_o,
   output logic [6:0]          y_o,
   output logic [COLOUR_W-1:0] colour_o,
   output logic                plot_o
);

   blit_state_t state_q, state_d;

   logic [7:0]       tgt_x_q, old_x_q;
   logic [6:0]       tgt_y_q, old_y_q;
   logic             old_v_q;
   logic             done_q, done_d;
   logic [7:0]       x_q;
   logic [6:0]       y_q;
   logic             plot_q;
   logic             src_draw_q;

   logic             ctr_clr, ctr_en, ctr_last;
   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic             load_tgt, commit_old;
   logic [7:0]       base_x;
   logic [6:0]       base_y;
   logic [8:0]       sum_x;
   logic [7:0]       sum_y;
   logic             in_range, scanning;

   sprite_scan_ctr u_scan (
      .clk    (clk),
      .rst_i  (rst_i),
      .clr_i  (ctr_clr),
      .en_i   (ctr_en),
      .col_o  (col),
      .row_o  (row),
      .last_o (ctr_last)
   );

   // Sums carry one extra bit so off-screen pixels are detected rather than wrapped.
   assign base_x   = (state_q == ERASE) ? old_x_q : tgt_x_q;
   assign base_y   = (state_q == ERASE) ? old_y_q : tgt_y_q;
   assign sum_x    = {1'b0, base_x} + 9'(col);
   assign sum_y    = {1'b0, base_y} + 8'(row);
   assign in_range = (sum_x < 9'(SCR_W)) && (sum_y < 8'(SCR_H));
   assign scanning = (state_q == ERASE) || (state_q == DRAW);

   assign spr_addr_o = {row, col};
   assign bg_addr_o  = {sum_y[6:0], sum_x[7:0]};

   always_comb begin
      state_d    = state_q;
      ctr_clr    = 1'b0;
      ctr_en     = 1'b0;
      done_d     = 1'b0;
      load_tgt   = 1'b0;
      commit_old = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_i && !done_q) begin
               load_tgt = 1'b1;
               ctr_clr  = 1'b1;
               state_d  = old_v_q ? ERASE : DRAW;
            end
         end
         ERASE: begin
            ctr_en = 1'b1;
            if (ctr_last) begin
               ctr_clr = 1'b1;
               state_d = DRAW;
            end
         end
         DRAW: begin
            ctr_en = 1'b1;
            if (ctr_last) begin
               ctr_clr = 1'b1;
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            done_d     = 1'b1;
            commit_old = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Pixel coordinates and source are delayed one stage to line up with the ROM read latency.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         state_q    <= IDLE;
         done_q     <= 1'b0;
         tgt_x_q    <= '0;
         tgt_y_q    <= '0;
         old_x_q    <= '0;
         old_y_q    <= '0;
         old_v_q    <= 1'b0;
         x_q        <= '0;
         y_q        <= '0;
         plot_q     <= 1'b0;
         src_draw_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         done_q     <= done_d;
         x_q        <= sum_x[7:0];
         y_q        <= sum_y[6:0];
         plot_q     <= scanning && in_range;
         src_draw_q <= (state_q == DRAW);
         if (load_tgt) begin
            tgt_x_q <= new_x_i;
            tgt_y_q <= new_y_i;
         end
         if (commit_old) begin
            old_x_q <= tgt_x_q;
            old_y_q <= tgt_y_q;
            old_v_q <= 1'b1;
         end
      end
   end

   // Busy holds through the done cycle so a request arriving with done is dropped.
   assign busy_o   = (state_q != IDLE) || done_q;
   assign done_o   = done_q;
   assign x_o      = x_q;
   assign y_o      = y_q;
   assign colour_o = plot_q ? (src_draw_q ? spr_colour_i : bg_colour_i) : '0;
`ifdef CAR_SPRITE_TRANSPARENT_EN
   assign plot_o   = plot_q && !(src_draw_q && (spr_colour_i == '0));
`else
   assign plot_o   = plot_q;
`endif

endmodule

// File: tb/tb_car_sprite_blitter.sv
// Directed bench for car_sprite_blitter: ROM models plus a scoreboard of expected plotted pixels.
module tb_car_sprite_blitter;
   import car_game_pkg::*;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        req_i;
   logic [7:0]  new_x_i;
   logic [6:0]  new_y_i;
   logic        busy_o, done_o, plot_o;
   logic [5:0]  spr_addr_o;
   logic [2:0]  spr_colour_i, bg_colour_i, colour_o;
   logic [14:0] bg_addr_o;
   logic [7:0]  x_o;
   logic [6:0]  y_o;

   int vectors = 0;
   int miscompares = 0;
   logic [17:0] expQ[$];
   logic        mOldV;
   logic [7:0]  mOldX;
   logic [6:0]  mOldY;
   int          lastPlots;

   car_sprite_blitter dut (
      .clk          (clk),
      .rst_i        (rst_i),
      .req_i        (req_i),
      .new_x_i      (new_x_i),
      .new_y_i      (new_y_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .spr_addr_o   (spr_addr_o),
      .spr_colour_i (spr_colour_i),
      .bg_addr_o    (bg_addr_o),
      .bg_colour_i  (bg_colour_i),
      .x_o          (x_o),
      .y_o          (y_o),
      .colour_o     (colour_o),
      .plot_o       (plot_o)
   );

   always #10 clk = ~clk;

   // Sprite column 0 is black; every other sprite pixel is non-zero.
   function automatic logic [2:0] sprRom(input logic [5:0] a);
      int v;
      if (a[2:0] == 3'd0) return 3'd0;
      v = ((int'(a[5:3]) + int'(a[2:0])) % 7) + 1;
      return 3'(v);
   endfunction

   function automatic logic [2:0] bgRom(input logic [14:0] a);
      int v;
      v = int'(a[14:8]) * 5 + int'(a[7:0]);
      return 3'(v);
   endfunction

   always_ff @(posedge clk) begin
      spr_colour_i <= sprRom(spr_addr_o);
      bg_colour_i  <= bgRom(bg_addr_o);
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic predict(input logic [7:0] tx, input logic [6:0] ty);
      int px, py;
      logic [2:0] c;
      if (mOldV) begin
         for (int r = 0; r < SPR_H; r++) begin
            for (int k = 0; k < SPR_W; k++) begin
               px = int'(mOldX) + k;
               py = int'(mOldY) + r;
               if (px < SCR_W && py < SCR_H)
                  expQ.push_back({8'(px), 7'(py), bgRom({7'(py), 8'(px)})});
            end
         end
      end
      for (int r = 0; r < SPR_H; r++) begin
         for (int k = 0; k < SPR_W; k++) begin
            px = int'(tx) + k;
            py = int'(ty) + r;
            c  = sprRom({3'(r), 3'(k)});
`ifdef CAR_SPRITE_TRANSPARENT_EN
            if (c == 3'd0) continue;
`endif
            if (px < SCR_W && py < SCR_H)
               expQ.push_back({8'(px), 7'(py), c});
         end
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_i = 1'b1;
      req_i = 1'b0;
      repeat (2) @(negedge clk);
      rst_i = 1'b0;
      mOldV = 1'b0;
   endtask

   // injectAt: cycle at which a second req is raised (-1 = on the done cycle, 0 = never).
   // abortAt: cycle at which reset is raised mid-operation (0 = never).
   task automatic applyStimulus(input string tag, input logic [7:0] tx, input logic [6:0] ty,
                                input int injectAt, input int abortAt);
      int expDone, expCount, plotCount, doneCount, doneCycle, inj;
      expDone = mOldV ? 130 : 66;
      inj = (injectAt < 0) ? expDone : injectAt;
      expQ.delete();
      predict(tx, ty);
      expCount = expQ.size();
      plotCount = 0;
      doneCount = 0;
      doneCycle = -1;
      @(negedge clk);
      req_i = 1'b1;
      new_x_i = tx;
      new_y_i = ty;
      @(posedge clk);
      for (int n = 1; n <= expDone + 3; n++) begin
         @(negedge clk);
         req_i = 1'b0;
         if (abortAt > 0 && n == abortAt + 1) begin
            checkOutput({tag, "_abortPlot"}, 32'(plot_o), 32'd0);
            checkOutput({tag, "_abortBusy"}, 32'(busy_o), 32'd0);
            rst_i = 1'b0;
            mOldV = 1'b0;
            expQ.delete();
            return;
         end
         if (plot_o) begin
            plotCount++;
            if (expQ.size() == 0)
               checkOutput({tag, "_extraPlot"}, {14'd0, x_o, y_o, colour_o}, 32'hFFFF_FFFF);
            else
               checkOutput({tag, "_pix"}, {14'd0, x_o, y_o, colour_o}, {14'd0, expQ.pop_front()});
         end
         if (done_o) begin
            doneCount++;
            doneCycle = n;
         end
         if (n == 1) checkOutput({tag, "_busyStart"}, 32'(busy_o), 32'd1);
         if (n == expDone) checkOutput({tag, "_busyAtDone"}, 32'(busy_o), 32'd1);
         if (n == inj) begin
            req_i = 1'b1;
            new_x_i = 8'd10;
            new_y_i = 7'd10;
         end
         if (abortAt > 0 && n == abortAt) rst_i = 1'b1;
      end
      checkOutput({tag, "_doneCycle"}, 32'(doneCycle), 32'(expDone));
      checkOutput({tag, "_doneCount"}, 32'(doneCount), 32'd1);
      checkOutput({tag, "_plotCount"}, 32'(plotCount), 32'(expCount));
      checkOutput({tag, "_queueLeft"}, 32'(expQ.size()), 32'd0);
      checkOutput({tag, "_busyEnd"}, 32'(busy_o), 32'd0);
      lastPlots = plotCount;
      mOldV = 1'b1;
      mOldX = tx;
      mOldY = ty;
   endtask

   initial begin
      rst_i = 1'b1;
      req_i = 1'b0;
      new_x_i = '0;
      new_y_i = '0;
      mOldV = 1'b0;
      mOldX = '0;
      mOldY = '0;
      repeat (3) @(negedge clk);
      checkOutput("rstBusy",   32'(busy_o),     32'd0);
      checkOutput("rstDone",   32'(done_o),     32'd0);
      checkOutput("rstPlot",   32'(plot_o),     32'd0);
      checkOutput("rstX",      32'(x_o),        32'd0);
      checkOutput("rstY",      32'(y_o),        32'd0);
      checkOutput("rstColour", 32'(colour_o),   32'd0);
      checkOutput("rstSprA",   32'(spr_addr_o), 32'd0);
      checkOutput("rstBgA",    32'(bg_addr_o),  32'd0);
      rst_i = 1'b0;
      $display("[TB] draw-only request at (75,70)");
      applyStimulus("draw75", 8'd75, 7'd70, 0, 0);
`ifdef CAR_SPRITE_TRANSPARENT_EN
      checkOutput("draw75_count", 32'(lastPlots), 32'd56);
`else
      checkOutput("draw75_count", 32'(lastPlots), 32'd64);
`endif
      $display("[TB] erase+draw move to (40,70) with ignored mid-op req");
      applyStimulus("move40", 8'd40, 7'd70, 30, 0);
      doReset();
      $display("[TB] clipped request at (155,115) with req on done cycle");
      applyStimulus("clip", 8'd155, 7'd115, -1, 0);
`ifdef CAR_SPRITE_TRANSPARENT_EN
      checkOutput("clip_count", 32'(lastPlots), 32'd20);
`else
      checkOutput("clip_count", 32'(lastPlots), 32'd25);
`endif
      $display("[TB] reset during DRAW");
      applyStimulus("abort", 8'd20, 7'd30, 0, 100);
      applyStimulus("afterAbort", 8'd60, 7'd50, 0, 0);
      applyStimulus("origin", 8'd0, 7'd0, 0, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
